// File: rtl/flash_ctrl.sv
// flash_ctrl: registered CE/OE/WE strobe sequencer for an 8-bit parallel NOR flash,
// with optional post-write wait on the device STS ready line.
module flash_ctrl #(
  parameter int unsigned SETUP_CYC   = 2,
  parameter int unsigned PULSE_CYC   = 3,
  parameter int unsigned HOLD_CYC    = 1,
  parameter int unsigned STS_WAIT    = 0,
  parameter int unsigned STS_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_rd,
  input  logic       req_wr,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [7:0] rdata,
  output logic [7:0] NF_A,
  inout  wire  [7:0] NF_D,
  output logic       NF_CE,
  output logic       NF_OE,
  output logic       NF_WE,
  output logic       NF_BYTE,
  output logic       NF_WP,
  output logic       NF_RP,
  input  logic       NF_STS
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SETUP    = 3'd1,
    STROBE   = 3'd2,
    HOLD     = 3'd3,
    WAIT_STS = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             is_wr, wr_nxt;
  logic             d_oe, d_oe_nxt;
  logic [7:0]       d_out, d_out_nxt;
  logic [7:0]       a_nxt;
  logic             busy_nxt, done_nxt, err_nxt;
  logic             ce_nxt, oe_nxt, we_nxt;
  logic             cap;
  logic             sts_s1, sts_s2;

  assign NF_D    = d_oe ? d_out : 8'bzzzz_zzzz;
  assign NF_BYTE = 1'b0;
  assign NF_WP   = 1'b1;

  // Next-state and next-output logic; strobes default high and are re-asserted each STROBE cycle.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    wr_nxt    = is_wr;
    d_oe_nxt  = d_oe;
    d_out_nxt = d_out;
    a_nxt     = NF_A;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    ce_nxt    = NF_CE;
    oe_nxt    = 1'b1;
    we_nxt    = 1'b1;
    cap       = 1'b0;
    case (state)
      IDLE: begin
        if (req_wr || req_rd) begin
          state_nxt = SETUP;
          cnt_nxt   = CNT_W'(SETUP_CYC - 1);
          wr_nxt    = req_wr;
          d_oe_nxt  = req_wr;
          d_out_nxt = wdata;
          a_nxt     = addr;
          busy_nxt  = 1'b1;
          ce_nxt    = 1'b0;
        end
      end
      SETUP: begin
        if (cnt == '0) begin
          state_nxt = STROBE;
          cnt_nxt   = CNT_W'(PULSE_CYC - 1);
          oe_nxt    = is_wr;
          we_nxt    = !is_wr;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      STROBE: begin
        if (cnt == '0) begin
          state_nxt = HOLD;
          cnt_nxt   = CNT_W'(HOLD_CYC - 1);
          cap       = !is_wr;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
          oe_nxt  = is_wr;
          we_nxt  = !is_wr;
        end
      end
      HOLD: begin
        if (cnt == '0) begin
          ce_nxt   = 1'b1;
          d_oe_nxt = 1'b0;
          if (is_wr && (STS_WAIT != 0)) begin
            state_nxt = WAIT_STS;
            cnt_nxt   = CNT_W'(STS_TIMEOUT - 1);
          end else begin
            state_nxt = IDLE;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
          end
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      WAIT_STS: begin
        // Ready is checked before the timeout so a last-cycle STS still completes cleanly.
        if (sts_s2) begin
          state_nxt = IDLE;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
        end else if (cnt == '0) begin
          state_nxt = IDLE;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
          err_nxt   = 1'b1;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      is_wr  <= 1'b0;
      d_oe   <= 1'b0;
      d_out  <= 8'h00;
      NF_A   <= 8'h00;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      NF_CE  <= 1'b1;
      NF_OE  <= 1'b1;
      NF_WE  <= 1'b1;
      NF_RP  <= 1'b0;
      rdata  <= 8'h00;
      sts_s1 <= 1'b0;
      sts_s2 <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      is_wr  <= wr_nxt;
      d_oe   <= d_oe_nxt;
      d_out  <= d_out_nxt;
      NF_A   <= a_nxt;
      busy   <= busy_nxt;
      done   <= done_nxt;
      err    <= err_nxt;
      NF_CE  <= ce_nxt;
      NF_OE  <= oe_nxt;
      NF_WE  <= we_nxt;
      NF_RP  <= 1'b1;
      sts_s1 <= NF_STS;
      sts_s2 <= sts_s1;
      if (cap) rdata <= NF_D;
    end
  end

endmodule

// File: tb/tb_flash_ctrl.sv
// tb_flash_ctrl: randomized self-checking bench for flash_ctrl with a flash device model
// and a transaction-level timing/memory reference.
module tb_flash_ctrl;

  localparam int unsigned S   = 2;
  localparam int unsigned P   = 3;
  localparam int unsigned H   = 1;
  localparam int unsigned SPH = S + P + H;
  localparam int unsigned T1  = 10;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sel;
  logic       req_rd, req_wr;
  logic [7:0] addr, wdata;
  logic       park_en;
  logic       sts1;

  logic       busy0, done0, err0, ce0, oe0, we0, byte0, wp0, rp0;
  logic       busy1, done1, err1, ce1, oe1, we1, byte1, wp1, rp1;
  logic [7:0] rdata0, a0, rdata1, a1;
  wire  [7:0] d0, d1;

  logic [7:0] dev_mem0 [256];
  logic [7:0] dev_mem1 [256];
  logic [7:0] ref_mem  [2][256];
  logic [7:0] ref_rdata [2];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  flash_ctrl u_dut0 (
    .clk(clk), .rst_n(rst_n), .req_rd(req_rd && !sel), .req_wr(req_wr && !sel),
    .addr(addr), .wdata(wdata), .busy(busy0), .done(done0), .err(err0), .rdata(rdata0),
    .NF_A(a0), .NF_D(d0), .NF_CE(ce0), .NF_OE(oe0), .NF_WE(we0), .NF_BYTE(byte0),
    .NF_WP(wp0), .NF_RP(rp0), .NF_STS(1'b0)
  );

  flash_ctrl #(.STS_WAIT(1), .STS_TIMEOUT(T1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req_rd(req_rd && sel), .req_wr(req_wr && sel),
    .addr(addr), .wdata(wdata), .busy(busy1), .done(done1), .err(err1), .rdata(rdata1),
    .NF_A(a1), .NF_D(d1), .NF_CE(ce1), .NF_OE(oe1), .NF_WE(we1), .NF_BYTE(byte1),
    .NF_WP(wp1), .NF_RP(rp1), .NF_STS(sts1)
  );

  // Flash device model: drives array data while OE/CE are low, logs a byte on WE rising.
  wire       rd_en0 = !oe0 && !ce0;
  wire       rd_en1 = !oe1 && !ce1;
  wire [7:0] drv0   = rd_en0 ? dev_mem0[a0] : 8'h00;
  wire [7:0] drv1   = rd_en1 ? dev_mem1[a1] : 8'h00;
  assign d0 = (park_en || rd_en0) ? drv0 : 8'hzz;
  assign d1 = (park_en || rd_en1) ? drv1 : 8'hzz;

  always @(posedge we0) if (rst_n && !ce0) dev_mem0[a0] = d0;
  always @(posedge we1) if (rst_n && !ce1) dev_mem1[a1] = d1;

  wire       o_busy  = sel ? busy1  : busy0;
  wire       o_done  = sel ? done1  : done0;
  wire       o_err   = sel ? err1   : err0;
  wire       o_ce    = sel ? ce1    : ce0;
  wire       o_oe    = sel ? oe1    : oe0;
  wire       o_we    = sel ? we1    : we0;
  wire       o_rp    = sel ? rp1    : rp0;
  wire [7:0] o_a     = sel ? a1     : a0;
  wire [7:0] o_d     = sel ? d1     : d0;
  wire [7:0] o_rdata = sel ? rdata1 : rdata0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One transaction; expected timing comes from S/P/H plus the STS rules, memory from ref_mem.
  task automatic run_txn(input logic rd, input logic wr, input logic [7:0] a,
                         input logic [7:0] d, input int sts_k, input logic spur);
    int         done_cyc, stb_first, stb_cnt, oth_cnt, ce_cnt, a_bad, d_bad, busy_bad, err_bad;
    int         exp_done;
    logic       err_seen, exp_err, is_wr;
    logic [7:0] exp_bus;
    is_wr = wr;
    done_cyc = 0; stb_first = 0; stb_cnt = 0; oth_cnt = 0; ce_cnt = 0;
    a_bad = 0; d_bad = 0; busy_bad = 0; err_bad = 0; err_seen = 1'b0;
    exp_done = int'(SPH) + 1;
    exp_err  = 1'b0;
    if (is_wr && sel) begin
      if (sts_k > 0 && sts_k + 2 <= int'(T1)) exp_done = int'(SPH) + sts_k + 3;
      else begin
        exp_done = int'(SPH + T1) + 1;
        exp_err  = 1'b1;
      end
    end
    park_en = !is_wr;
    req_rd = rd; req_wr = wr; addr = a; wdata = d;
    for (int c = 1; c <= 60 && done_cyc == 0; c++) begin
      @(negedge clk);
      if (o_done) begin
        done_cyc = c;
        err_seen = o_err;
        if (o_busy) busy_bad++;
      end else begin
        if (!o_busy) busy_bad++;
        if (o_err) err_bad++;
      end
      if (!o_ce) begin
        ce_cnt++;
        if (o_a !== a) a_bad++;
        exp_bus = is_wr ? d : (!o_oe ? ref_mem[sel][a] : 8'h00);
        if (o_d !== exp_bus) d_bad++;
      end
      if (!(is_wr ? o_we : o_oe)) begin
        stb_cnt++;
        if (stb_first == 0) stb_first = c;
      end
      if (!(is_wr ? o_oe : o_we)) oth_cnt++;
      if (c == 1) begin
        req_rd = 1'b0; req_wr = 1'b0;
        addr = 8'($urandom); wdata = 8'($urandom);
      end
      if (spur && c == 3) req_rd = 1'b1;
      if (spur && c == 4) req_rd = 1'b0;
      if (sts_k > 0 && c == int'(SPH) + sts_k) sts1 = 1'b1;
    end
    sts1 = 1'b0;
    if (done_cyc == 0) check("done_timeout", 0, 1);
    check("done_cyc", done_cyc, exp_done);
    check("err_at_done", 32'(err_seen), 32'(exp_err));
    check("err_stray", err_bad, 0);
    check("busy", busy_bad, 0);
    check("stb_start", stb_first, S + 1);
    check("stb_len", stb_cnt, P);
    check("other_stb", oth_cnt, 0);
    check("ce_len", ce_cnt, SPH);
    check("addr_bus", a_bad, 0);
    check("data_bus", d_bad, 0);
    if (is_wr) ref_mem[sel][a] = d;
    else       ref_rdata[sel] = ref_mem[sel][a];
    check("rdata", 32'(o_rdata), 32'(ref_rdata[sel]));
    if (is_wr) check("dev_log", 32'(sel ? dev_mem1[a] : dev_mem0[a]), 32'(d));
    if (spur) begin
      @(negedge clk);
      check("no_requeue", 32'({o_busy, o_ce}), 32'(2'b01));
    end
  endtask

  task automatic release_reset();
    rst_n = 1'b1;
    #1;
    check("rp_after_release", 32'(o_rp), 0);
    @(negedge clk);
    check("rp_rise", 32'(o_rp), 1);
  endtask

  initial begin
    int   kind, dn;
    logic rd, wr, spur;
    sel = 1'b0; rst_n = 1'b0; req_rd = 1'b0; req_wr = 1'b0;
    addr = 8'h00; wdata = 8'h00; park_en = 1'b1; sts1 = 1'b0;
    ref_rdata[0] = 8'h00; ref_rdata[1] = 8'h00;
    for (int i = 0; i < 256; i++) begin
      ref_mem[0][i] = 8'h00;
      ref_mem[1][i] = 8'h00;
    end

    repeat (5) @(negedge clk);
    check("rst_ce", 32'(o_ce), 1);
    check("rst_oe", 32'(o_oe), 1);
    check("rst_we", 32'(o_we), 1);
    check("rst_rp", 32'(o_rp), 0);
    check("rst_busy_done_err", 32'({o_busy, o_done, o_err}), 0);
    check("rst_rdata", 32'(o_rdata), 0);
    check("rst_addr", 32'(o_a), 0);
    check("rst_bus_released", 32'(o_d), 0);
    check("nf_byte", 32'(byte0), 0);
    check("nf_wp", 32'(wp0), 1);
    release_reset();

    run_txn(1'b0, 1'b1, 8'h13, 8'hA5, 0, 1'b0);
    run_txn(1'b1, 1'b0, 8'h13, 8'h00, 0, 1'b0);
    run_txn(1'b1, 1'b1, 8'h02, 8'h3C, 0, 1'b1);
    run_txn(1'b1, 1'b0, 8'h02, 8'h00, 0, 1'b0);

    // Reset during the second WE-low cycle of a write must abort with no completion.
    park_en = 1'b0;
    req_wr = 1'b1; addr = 8'h13; wdata = 8'h5A;
    @(negedge clk);
    req_wr = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_we_low", 32'(o_we), 0);
    rst_n = 1'b0; park_en = 1'b1;
    #1;
    check("abort_we", 32'(o_we), 1);
    check("abort_ce", 32'(o_ce), 1);
    check("abort_bus", 32'(o_d), 0);
    check("abort_busy", 32'(o_busy), 0);
    dn = 0;
    repeat (3) begin
      @(negedge clk);
      if (o_done) dn++;
    end
    check("abort_no_done", dn, 0);
    ref_rdata[0] = 8'h00; ref_rdata[1] = 8'h00;
    release_reset();
    run_txn(1'b1, 1'b0, 8'h13, 8'h00, 0, 1'b0);

    for (int i = 0; i < 16; i++) run_txn(1'b0, 1'b1, 8'(i), 8'($urandom), 0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      kind = int'($urandom_range(0, 2));
      rd   = (kind != 1);
      wr   = (kind != 0);
      spur = ($urandom_range(0, 3) == 0);
      run_txn(rd, wr, 8'($urandom_range(0, 15)), 8'($urandom), 0, spur);
    end

    @(negedge clk);
    sel = 1'b1;
    run_txn(1'b0, 1'b1, 8'h21, 8'h77, 0, 1'b0);
    run_txn(1'b0, 1'b1, 8'h22, 8'h88, 4, 1'b0);
    run_txn(1'b0, 1'b1, 8'h23, 8'h99, 8, 1'b0);
    run_txn(1'b0, 1'b1, 8'h24, 8'hAA, 9, 1'b0);
    for (int i = 0; i < 6; i++)
      run_txn(1'b0, 1'b1, 8'($urandom), 8'($urandom), int'($urandom_range(0, 12)), 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
